// File: rtl/bp_pht_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bp_pht_ctrl                                                      |
// | Brief   : PHT controller: init sweep, lookups, queued 2-bit counter updates|
// |           Optional gshare indexing under macro BP_GSHARE_EN.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bp_pht_ctrl #(
   parameter int IDX_W    = 6,
   parameter int UQ_DEPTH = 4,
   parameter int GHR_W    = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             lkp_valid,
   input  logic [IDX_W-1:0] lkp_idx,
   output logic             lkp_ready,
   output logic             pred_valid,
   output logic             pred_taken,
   output logic [1:0]       pred_stt,
   output logic [IDX_W-1:0] pred_idx,
   input  logic             upd_valid,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_taken,
   input  logic [1:0]       upd_stt,
   output logic             upd_ready,
   output logic             init_busy
);

   localparam int c_AW = $clog2(UQ_DEPTH);
   localparam int c_PW = c_AW + 1;
   localparam logic [c_PW-1:0] c_FULL = c_PW'(UQ_DEPTH);

   typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

   state_t           r_state;
   logic [IDX_W-1:0] r_sweep;
   logic [1:0]       r_pht   [2**IDX_W];
   logic [IDX_W-1:0] r_q_idx [UQ_DEPTH];
   logic [1:0]       r_q_stt [UQ_DEPTH];
   logic             r_q_tkn [UQ_DEPTH];
   logic [c_PW-1:0]  r_wr_ptr, r_rd_ptr;
   logic             r_lkp_ready, r_upd_ready, r_init_busy;
   logic             r_pred_valid, r_pred_taken;
   logic [1:0]       r_pred_stt;
   logic [IDX_W-1:0] r_pred_idx;

   logic [IDX_W-1:0] w_fidx;
   logic [c_PW-1:0]  w_count, w_count_nxt;
   logic [c_AW-1:0]  w_rslot, w_wslot, w_slot;
   logic             w_rd, w_enq, w_deq, w_nxt_run;
   logic             w_fwd_hit, w_haz_nxt;
   logic [1:0]       w_fwd_stt, w_rd_stt;

   function automatic logic [1:0] f_sat(input logic [1:0] stt, input logic tkn);
      if (tkn) return (stt == 2'b11) ? 2'b11 : stt + 2'd1;
      else     return (stt == 2'b00) ? 2'b00 : stt - 2'd1;
   endfunction

   if (GHR_W > IDX_W) begin : g_ghr_too_long
      // Unsupported configuration: history longer than the index; no hardware.
   end

`ifdef BP_GSHARE_EN
   logic [GHR_W-1:0] r_ghr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_ghr <= '0;
      else if (w_enq) r_ghr <= {r_ghr[GHR_W-2:0], upd_taken};
   end

   assign w_fidx = lkp_idx ^ IDX_W'(r_ghr);
`else
   assign w_fidx = lkp_idx;
`endif

   assign w_count     = r_wr_ptr - r_rd_ptr;
   assign w_rslot     = r_rd_ptr[c_AW-1:0];
   assign w_wslot     = r_wr_ptr[c_AW-1:0];
   assign w_rd        = lkp_valid & r_lkp_ready;
   assign w_enq       = upd_valid & r_upd_ready;
   assign w_deq       = (r_state == ST_RUN) & ~w_rd & (w_count != '0);
   assign w_count_nxt = w_count + c_PW'(w_enq) - c_PW'(w_deq);
   assign w_nxt_run   = (r_state == ST_RUN) || (r_sweep == '1);

   // Youngest queued entry for the lookup index gives the value the table will
   // finally hold; it also decides whether a held lookup must keep stalling.
   always_comb begin
      w_fwd_hit = 1'b0;
      w_fwd_stt = 2'b00;
      w_haz_nxt = 1'b0;
      w_slot    = '0;
      for (int i = 0; i < UQ_DEPTH; i++) begin
         w_slot = w_rslot + c_AW'(i);
         if ((c_PW'(i) < w_count) && (r_q_idx[w_slot] == w_fidx)) begin
            w_fwd_hit = 1'b1;
            w_fwd_stt = f_sat(r_q_stt[w_slot], r_q_tkn[w_slot]);
            if (!(w_deq && (i == 0))) w_haz_nxt = 1'b1;
         end
      end
      if (w_enq && (upd_idx == w_fidx)) w_haz_nxt = 1'b1;
      w_haz_nxt = w_haz_nxt & lkp_valid & ~w_rd;
   end

   assign w_rd_stt = w_fwd_hit ? w_fwd_stt : r_pht[w_fidx];

   always_ff @(posedge clk) begin
      if (r_state == ST_INIT) r_pht[r_sweep] <= 2'b01;
      else if (w_deq)         r_pht[r_q_idx[w_rslot]] <= f_sat(r_q_stt[w_rslot], r_q_tkn[w_rslot]);
   end

   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_q_idx[w_wslot] <= upd_idx;
         r_q_stt[w_wslot] <= upd_stt;
         r_q_tkn[w_wslot] <= upd_taken;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_INIT;
         r_sweep      <= '0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_lkp_ready  <= 1'b0;
         r_upd_ready  <= 1'b0;
         r_init_busy  <= 1'b1;
         r_pred_valid <= 1'b0;
         r_pred_taken <= 1'b0;
         r_pred_stt   <= 2'b00;
         r_pred_idx   <= '0;
      end else begin
         if (r_state == ST_INIT) begin
            r_sweep <= r_sweep + IDX_W'(1);
            if (r_sweep == '1) r_state <= ST_RUN;
         end
         if (w_enq) r_wr_ptr <= r_wr_ptr + c_PW'(1);
         if (w_deq) r_rd_ptr <= r_rd_ptr + c_PW'(1);
         r_init_busy  <= ~w_nxt_run;
         r_upd_ready  <= w_nxt_run && (w_count_nxt != c_FULL);
         r_lkp_ready  <= w_nxt_run && (w_count_nxt != c_FULL) && !w_haz_nxt;
         r_pred_valid <= w_rd;
         if (w_rd) begin
            r_pred_stt   <= w_rd_stt;
            r_pred_taken <= w_rd_stt[1];
            r_pred_idx   <= w_fidx;
         end
      end
   end

   assign lkp_ready  = r_lkp_ready;
   assign upd_ready  = r_upd_ready;
   assign init_busy  = r_init_busy;
   assign pred_valid = r_pred_valid;
   assign pred_taken = r_pred_taken;
   assign pred_stt   = r_pred_stt;
   assign pred_idx   = r_pred_idx;

endmodule
`default_nettype wire

// File: tb/tb_bp_pht_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_bp_pht_ctrl                                                   |
// | Brief   : Directed self-checking bench for bp_pht_ctrl (IDX_W=6, UQ=4).    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_bp_pht_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       lkp_valid = 1'b0;
   logic [5:0] lkp_idx = '0;
   logic       lkp_ready;
   logic       pred_valid, pred_taken;
   logic [1:0] pred_stt;
   logic [5:0] pred_idx;
   logic       upd_valid = 1'b0;
   logic [5:0] upd_idx = '0;
   logic       upd_taken = 1'b0;
   logic [1:0] upd_stt = '0;
   logic       upd_ready, init_busy;

   int n_vec = 0;
   int n_err = 0;
   int n;

   bp_pht_ctrl #(.IDX_W(6), .UQ_DEPTH(4), .GHR_W(6)) dut (
      .clk(clk), .rst_n(rst_n),
      .lkp_valid(lkp_valid), .lkp_idx(lkp_idx), .lkp_ready(lkp_ready),
      .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_stt(pred_stt), .pred_idx(pred_idx),
      .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_stt(upd_stt),
      .upd_ready(upd_ready), .init_busy(init_busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lookup(input logic [5:0] idx);
      int k;
      lkp_valid = 1'b1;
      lkp_idx   = idx;
      k = 0;
      while (!lkp_ready && k < 40) begin tick(); k++; end
      chk("lkp_accept_in_time", 8'(k < 40), 8'd1);
      tick();
      lkp_valid = 1'b0;
   endtask

   task automatic update(input logic [5:0] idx, input logic tkn, input logic [1:0] stt);
      int k;
      upd_valid = 1'b1;
      upd_idx   = idx;
      upd_taken = tkn;
      upd_stt   = stt;
      k = 0;
      while (!upd_ready && k < 40) begin tick(); k++; end
      chk("upd_accept_in_time", 8'(k < 40), 8'd1);
      tick();
      upd_valid = 1'b0;
   endtask

   task automatic init_wait();
      int  k;
      logic bad;
      k = 0;
      bad = 1'b0;
      while (init_busy && k < 200) begin
         if (lkp_ready || upd_ready) bad = 1'b1;
         tick();
         k++;
      end
      chk("init_cycles", 8'(k), 8'd64);
      chk("init_ready_low", 8'(bad), 8'd0);
      chk("run_lkp_ready", 8'(lkp_ready), 8'd1);
      chk("run_upd_ready", 8'(upd_ready), 8'd1);
   endtask

   initial begin
      // Reset values
      repeat (3) tick();
      chk("rst_pred_valid", 8'(pred_valid), 8'd0);
      chk("rst_pred_taken", 8'(pred_taken), 8'd0);
      chk("rst_pred_stt", 8'(pred_stt), 8'd0);
      chk("rst_pred_idx", 8'(pred_idx), 8'd0);
      chk("rst_lkp_ready", 8'(lkp_ready), 8'd0);
      chk("rst_upd_ready", 8'(upd_ready), 8'd0);
      chk("rst_init_busy", 8'(init_busy), 8'd1);
      rst_n = 1'b1;
      init_wait();

      lookup(6'd20);
      chk("init_pred_valid", 8'(pred_valid), 8'd1);
      chk("init_pred_stt", 8'(pred_stt), 8'h1);
      chk("init_pred_taken", 8'(pred_taken), 8'd0);
      chk("init_pred_idx", 8'(pred_idx), 8'd20);
      tick();
      chk("pred_valid_one_cycle", 8'(pred_valid), 8'd0);

      // Saturating taken chain on idx 5
      update(6'd5, 1'b1, 2'b01); repeat (3) tick();
      lookup(6'd5);
      chk("sat_01_to_10", 8'(pred_stt), 8'h2);
      update(6'd5, 1'b1, 2'b10); repeat (3) tick();
      lookup(6'd5);
      chk("sat_10_to_11", 8'(pred_stt), 8'h3);
      update(6'd5, 1'b1, 2'b11); repeat (3) tick();
      lookup(6'd5);
      chk("sat_11_hold", 8'(pred_stt), 8'h3);
      chk("sat_11_taken", 8'(pred_taken), 8'd1);

      // Boundaries: not-taken at 00, taken at 11, not-taken at 10
      update(6'd7, 1'b0, 2'b00); repeat (3) tick();
      lookup(6'd7);
      chk("sat_00_hold", 8'(pred_stt), 8'h0);
      update(6'd8, 1'b1, 2'b11); repeat (3) tick();
      lookup(6'd8);
      chk("sat_11_hold_b", 8'(pred_stt), 8'h3);
      update(6'd10, 1'b0, 2'b10); repeat (3) tick();
      lookup(6'd10);
      chk("sat_10_down", 8'(pred_stt), 8'h1);

      // Queued update for idx 9, immediate lookup must see the new value
      update(6'd9, 1'b1, 2'b01);
      lookup(6'd9);
      chk("hazard_fresh_stt", 8'(pred_stt), 8'h2);
      chk("hazard_pred_idx", 8'(pred_idx), 8'd9);
      repeat (3) tick();

      // Fill queue while lookups stream
      lkp_valid = 1'b1; lkp_idx = 6'd30;
      upd_valid = 1'b1; upd_taken = 1'b1; upd_stt = 2'b01;
      for (int i = 0; i < 4; i++) begin upd_idx = 6'(40 + i); tick(); end
      upd_valid = 1'b0;
      chk("full_upd_ready", 8'(upd_ready), 8'd0);
      chk("full_lkp_ready", 8'(lkp_ready), 8'd0);
      chk("full_last_pred", 8'(pred_valid), 8'd1);
      tick();
      chk("full_stall_no_pred", 8'(pred_valid), 8'd0);
      chk("full_resume_lkp", 8'(lkp_ready), 8'd1);
      chk("full_resume_upd", 8'(upd_ready), 8'd1);
      tick();
      chk("resume_pred_valid", 8'(pred_valid), 8'd1);
      chk("resume_pred_stt", 8'(pred_stt), 8'h1);
      chk("resume_pred_idx", 8'(pred_idx), 8'd30);
      lkp_valid = 1'b0;
      repeat (5) tick();

      // Full queue, then held lookup hits youngest entry: stall until drained
      lkp_valid = 1'b1; lkp_idx = 6'd30;
      upd_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin upd_idx = 6'(44 + i); tick(); end
      upd_valid = 1'b0;
      lkp_idx = 6'd47;
      tick();
      chk("haz_stall", 8'(lkp_ready), 8'd0);
      n = 0;
      while (!lkp_ready && n < 20) begin tick(); n++; end
      chk("haz_wait_cycles", 8'(n), 8'd3);
      tick();
      lkp_valid = 1'b0;
      chk("haz_pred_valid", 8'(pred_valid), 8'd1);
      chk("haz_pred_stt", 8'(pred_stt), 8'h2);
      chk("haz_pred_taken", 8'(pred_taken), 8'd1);
      chk("haz_pred_idx", 8'(pred_idx), 8'd47);

      // Reset mid-drain with 3 queued entries
      lkp_valid = 1'b1; lkp_idx = 6'd30;
      upd_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin upd_idx = 6'(50 + i); tick(); end
      upd_valid = 1'b0; lkp_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_init_busy", 8'(init_busy), 8'd1);
      chk("mid_rst_lkp_ready", 8'(lkp_ready), 8'd0);
      chk("mid_rst_upd_ready", 8'(upd_ready), 8'd0);
      chk("mid_rst_pred_valid", 8'(pred_valid), 8'd0);
      chk("mid_rst_pred_stt", 8'(pred_stt), 8'h0);
      chk("mid_rst_pred_idx", 8'(pred_idx), 8'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      init_wait();
      lookup(6'd50);
      chk("lost_upd_50", 8'(pred_stt), 8'h1);
      lookup(6'd52);
      chk("lost_upd_52", 8'(pred_stt), 8'h1);
      lookup(6'd5);
      chk("reinit_idx5", 8'(pred_stt), 8'h1);

`ifdef BP_GSHARE_EN
      update(6'd0, 1'b1, 2'b01);
      update(6'd1, 1'b0, 2'b01);
      update(6'd2, 1'b1, 2'b01);
      lookup(6'd0);
      chk("gshare_pred_idx", 8'(pred_idx), 8'h05);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
